// File: rtl/div_sub_shift.sv
// Restoring shift-subtract divider: 2*WIDTH-bit dividend / WIDTH-bit divisor; DIV_BY_ZERO_DETECT_EN adds a one-cycle zero-divisor exit.
// Latency 2*WIDTH edges from accepted start to done (1 with zero detect); start is ignored while busy.
module div_sub_shift #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic [2*WIDTH-1:0] quot,
  output logic [WIDTH-1:0]   rem,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero
);

  localparam int DW = 2 * WIDTH;
  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [DW-1:0]    d_q, d_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DW-1:0]    quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;
  logic             ge;
  logic [WIDTH-1:0] r_step;
  logic [DW-1:0]    d_step;
  logic             zero_exit;

  // The partial remainder only ever needs WIDTH bits between iterations: a
  // subtracted result is below B, and a kept trial is below B as well. The
  // extra bit lives only in the trial value that feeds the compare.
  assign trial  = {r_q, d_q[DW-1]};
  assign ge     = trial >= {1'b0, b_q};
  assign diff   = trial[WIDTH-1:0] - b_q;
  assign r_step = ge ? diff : trial[WIDTH-1:0];
  assign d_step = {d_q[DW-2:0], ge};

`ifdef DIV_BY_ZERO_DETECT_EN
  assign zero_exit = (b_q == '0);
`else
  assign zero_exit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    b_d     = b_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          d_d     = dividend;
          b_d     = divisor;
          r_d     = '0;
          cnt_d   = CW'(DW);
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        if (zero_exit) begin
          quot_d  = '1;
          rem_d   = '0;
          dbz_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          d_d   = d_step;
          r_d   = r_step;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            quot_d  = d_step;
            rem_d   = r_step;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      d_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      b_q     <= b_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign quot        = quot_q;
  assign rem         = rem_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign div_by_zero = dbz_q;

endmodule
